sram_fill_checker: RTL and testbench

SRAM_FILL_CHECKER -- requirements
Module: sram_fill_checker

---
 rtl/hack_soc_pkg.sv | 18 +
 rtl/sram_pattern_gen.sv | 23 ++
 rtl/sram_fill_checker.sv | 156 +++++++++++++++
 tb/tb_sram_fill_checker.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_soc_pkg.sv
// Shared SoC definitions: SRAM fill-checker state encoding and pattern selectors.
package hack_soc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } fill_state_e;

  localparam logic PATTERN_ALTERNATE = 1'b0;
  localparam logic PATTERN_ADDRESS   = 1'b1;

endpackage

// File: rtl/sram_pattern_gen.sv
// Expected SRAM word for an address: alternating SEED/~SEED, or the address itself.
module sram_pattern_gen
  import hack_soc_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH    = 16,
  parameter int unsigned           ADDRESS_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] SEED          = WORD_WIDTH'(16'hFF00)
) (
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                     pattern_sel,
  output logic [WORD_WIDTH-1:0]    word_c
);

  always_comb begin
    word_c = SEED;
    case (pattern_sel)
      PATTERN_ALTERNATE: word_c = address[0] ? ~SEED : SEED;
      PATTERN_ADDRESS:   word_c = WORD_WIDTH'(address);
      default:           word_c = SEED;
    endcase
  end

endmodule

// File: rtl/sram_fill_checker.sv
// Writes a pattern to every SRAM word, reads it straight back and compares;
// hands the bus to video readout once the whole pass matches.
module sram_fill_checker
  import hack_soc_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH    = 16,
  parameter int unsigned           ADDRESS_WIDTH = 16,
  parameter int unsigned           WORD_COUNT    = 8192,
  parameter logic [WORD_WIDTH-1:0] SEED          = WORD_WIDTH'(16'hFF00)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     pattern_sel,
  input  logic                     initialized,
  input  logic                     busy,
  input  logic [WORD_WIDTH-1:0]    data_in,
  output logic                     request,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     write_enable,
  output logic [WORD_WIDTH-1:0]    data_out,
  output logic                     done,
  output logic                     error,
  output logic [ADDRESS_WIDTH-1:0] error_address,
  output logic                     video_mode
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(WORD_COUNT - 1);

  fill_state_e               state_q, state_d;
  logic                      pattern_q, pattern_d;
  logic                      busy_q;
  logic [WORD_WIDTH-1:0]     read_word_q, read_word_d;
  logic                      request_d, write_enable_d;
  logic                      done_d, error_d, video_mode_d;
  logic [ADDRESS_WIDTH-1:0]  address_d, error_address_d;
  logic [WORD_WIDTH-1:0]     data_out_d;
  logic                      xfer_done_c;

  // A transfer ends on the falling edge of busy while our request is still up.
  assign xfer_done_c = request && busy_q && !busy;

  // data_out is registered from the next address so it always tracks address.
  sram_pattern_gen #(
    .WORD_WIDTH   (WORD_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .SEED         (SEED)
  ) u_pattern_gen (
    .address    (address_d),
    .pattern_sel(pattern_d),
    .word_c     (data_out_d)
  );

  always_comb begin
    state_d         = state_q;
    pattern_d       = pattern_q;
    read_word_d     = read_word_q;
    request_d       = request;
    write_enable_d  = write_enable;
    address_d       = address;
    done_d          = done;
    error_d         = error;
    error_address_d = error_address;
    video_mode_d    = video_mode;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_d         = ST_WR_REQ;
          pattern_d       = pattern_sel;
          address_d       = '0;
          done_d          = 1'b0;
          error_d         = 1'b0;
          error_address_d = '0;
          video_mode_d    = 1'b0;
        end
      end
      ST_WR_REQ: begin
        request_d = 1'b0;
        if (initialized && !busy) begin
          request_d      = 1'b1;
          write_enable_d = 1'b1;
          state_d        = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (xfer_done_c) begin
          request_d = 1'b0;
          state_d   = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        request_d = 1'b0;
        if (initialized && !busy) begin
          request_d      = 1'b1;
          write_enable_d = 1'b0;
          state_d        = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (xfer_done_c) begin
          request_d   = 1'b0;
          read_word_d = data_in;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (read_word_q != data_out) begin
          state_d         = ST_FAIL;
          error_d         = 1'b1;
          error_address_d = address;
          video_mode_d    = 1'b0;
        end else if (address == LAST_ADDRESS) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          video_mode_d = 1'b1;
        end else begin
          address_d = address + ADDRESS_WIDTH'(1);
          state_d   = ST_WR_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pattern_q     <= PATTERN_ALTERNATE;
      busy_q        <= 1'b0;
      read_word_q   <= '0;
      request       <= 1'b0;
      write_enable  <= 1'b1;
      address       <= '0;
      data_out      <= SEED;
      done          <= 1'b0;
      error         <= 1'b0;
      error_address <= '0;
      video_mode    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      busy_q        <= busy;
      read_word_q   <= read_word_d;
      request       <= request_d;
      write_enable  <= write_enable_d;
      address       <= address_d;
      data_out      <= data_out_d;
      done          <= done_d;
      error         <= error_d;
      error_address <= error_address_d;
      video_mode    <= video_mode_d;
    end
  end

endmodule

// File: tb/tb_sram_fill_checker.sv
// Bench for sram_fill_checker: randomized-latency SRAM encoder model, access log
// and pattern reference computed directly from the addressing rules.
module tb_sram_fill_checker;

  localparam int unsigned WW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned WORDS = 10;
  localparam logic [WW-1:0] SEED = 16'hFF00;
  localparam logic [52:0] RESET_VEC = {1'b0, 1'b1, 16'h0000, SEED, 1'b0, 1'b0, 16'h0000, 1'b0};

  typedef struct {
    bit          we;
    int          addr;
    logic [WW-1:0] data;
    int          rise;
    int          fall;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          pattern_sel = 1'b0;
  logic          initialized = 1'b1;
  logic          busy = 1'b0;
  logic [WW-1:0] data_in = '0;
  logic          request;
  logic [AW-1:0] address;
  logic          write_enable;
  logic [WW-1:0] data_out;
  logic          done;
  logic          error;
  logic [AW-1:0] error_address;
  logic          video_mode;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int phase   = 0;
  int cnt     = 0;
  int blen    = 1;
  int corrupt_addr = -1;
  logic [WW-1:0] mem [16];
  acc_t cur;
  acc_t log_q[$];

  sram_fill_checker #(
    .WORD_WIDTH   (WW),
    .ADDRESS_WIDTH(AW),
    .WORD_COUNT   (WORDS),
    .SEED         (SEED)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .pattern_sel  (pattern_sel),
    .initialized  (initialized),
    .busy         (busy),
    .data_in      (data_in),
    .request      (request),
    .address      (address),
    .write_enable (write_enable),
    .data_out     (data_out),
    .done         (done),
    .error        (error),
    .error_address(error_address),
    .video_mode   (video_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Encoder model: random latency before busy, random busy length, then wait for request drop.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy  = 1'b0;
      phase = 0;
    end else begin
      case (phase)
        0: if (request) begin
          cur.we   = write_enable;
          cur.addr = int'(address);
          cur.rise = cycle;
          cur.data = '0;
          cnt      = $urandom_range(0, 2);
          blen     = $urandom_range(1, 3);
          phase    = 1;
        end
        1: if (cnt == 0) begin
          busy  = 1'b1;
          cnt   = blen - 1;
          phase = 2;
        end else cnt--;
        2: if (cnt == 0) begin
          busy = 1'b0;
          if (cur.we) begin
            if (cur.addr < 16) mem[cur.addr] = data_out;
            cur.data = data_out;
          end else begin
            data_in = (cur.addr < 16) ? mem[cur.addr] : '0;
            if (cur.addr == corrupt_addr) data_in = data_in ^ 16'h0001;
            cur.data = data_in;
          end
          phase = 3;
        end else cnt--;
        default: if (!request) begin
          cur.fall = cycle;
          log_q.push_back(cur);
          phase = 0;
        end
      endcase
    end
  end

  function automatic logic [WW-1:0] pat(input bit sel, input int a);
    if (sel) return WW'(a);
    return (a % 2 == 1) ? ~SEED : SEED;
  endfunction

  function automatic logic [52:0] out_vec();
    return {request, write_enable, address, data_out, done, error, error_address, video_mode};
  endfunction

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    pattern_sel = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (done || error) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", out_vec(), RESET_VEC);
    end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (out_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL idle_hold: got %h expected %h", out_vec(), RESET_VEC);
    end
  endtask

  task automatic test_fill(input bit sel);
    bit to;
    bit we_e;
    logic [48:0] got, exp;
    log_q.delete();
    corrupt_addr = -1;
    pulse_start(sel);
    wait_end(to);
    n_tests++;
    if (to !== 1'b0) begin
      n_fail++;
      $display("FAIL fill%0d_timeout: got timeout expected done", sel);
    end
    n_tests++;
    if ({done, error, video_mode, request} !== 4'b1010) begin
      n_fail++;
      $display("FAIL fill%0d_status: got %b expected 1010", sel, {done, error, video_mode, request});
    end
    n_tests++;
    if (log_q.size() != int'(2 * WORDS)) begin
      n_fail++;
      $display("FAIL fill%0d_count: got %0d expected %0d", sel, log_q.size(), 2 * WORDS);
    end else begin
      for (int i = 0; i < int'(2 * WORDS); i++) begin
        we_e = (i % 2 == 0);
        got  = {log_q[i].we, 16'(log_q[i].addr), log_q[i].data};
        exp  = {we_e, 16'(i / 2), pat(sel, i / 2)};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL fill%0d_access%0d: got %h expected %h", sel, i, got, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    log_q.delete();
    corrupt_addr = -1;
    pulse_start(1'b0);
    wait_end(to);
    n_tests++;
    if (to !== 1'b0 || log_q.size() != int'(2 * WORDS)) begin
      n_fail++;
      $display("FAIL b2b_pass: got timeout=%0d accesses=%0d expected 0 and %0d", to, log_q.size(), 2 * WORDS);
    end else begin
      for (int w = 0; w < int'(WORDS); w++) begin
        n_tests++;
        if (log_q[2*w+1].rise != log_q[2*w].fall + 1) begin
          n_fail++;
          $display("FAIL b2b_wr_to_rd%0d: got rise %0d expected %0d", w, log_q[2*w+1].rise, log_q[2*w].fall + 1);
        end
        if (w < int'(WORDS) - 1) begin
          n_tests++;
          if (log_q[2*w+2].rise != log_q[2*w+1].fall + 2) begin
            n_fail++;
            $display("FAIL b2b_rd_to_wr%0d: got rise %0d expected %0d", w, log_q[2*w+2].rise, log_q[2*w+1].fall + 2);
          end
        end
      end
    end
  endtask

  task automatic test_corrupt();
    bit to;
    int max_addr = 0;
    log_q.delete();
    corrupt_addr = 5;
    pulse_start(1'b0);
    wait_end(to);
    repeat (10) @(negedge clk);
    n_tests++;
    if (to !== 1'b0 || {done, error, video_mode, request} !== 4'b0100) begin
      n_fail++;
      $display("FAIL corrupt_status: got to=%0d flags=%b expected 0 and 0100", to, {done, error, video_mode, request});
    end
    n_tests++;
    if (error_address !== 16'd5) begin
      n_fail++;
      $display("FAIL corrupt_error_address: got %0d expected 5", error_address);
    end
    foreach (log_q[i]) if (log_q[i].addr > max_addr) max_addr = log_q[i].addr;
    n_tests++;
    if (log_q.size() != 12 || max_addr != 5) begin
      n_fail++;
      $display("FAIL corrupt_no_more_access: got %0d accesses max addr %0d expected 12 and 5", log_q.size(), max_addr);
    end
  endtask

  task automatic test_start_in_fail();
    bit to;
    int bad = 0;
    log_q.delete();
    corrupt_addr = -1;
    pulse_start(1'b1);
    n_tests++;
    if ({error, error_address, address, done} !== 34'd0) begin
      n_fail++;
      $display("FAIL restart_clear: got err=%0d ea=%0d addr=%0d done=%0d expected all 0", error, error_address, address, done);
    end
    wait_end(to);
    foreach (log_q[i]) if (log_q[i].addr != i / 2 || log_q[i].data !== pat(1'b1, i / 2)) bad++;
    n_tests++;
    if (to !== 1'b0 || done !== 1'b1 || error !== 1'b0 || log_q.size() != int'(2 * WORDS) || bad != 0) begin
      n_fail++;
      $display("FAIL restart_pass: got done=%0d error=%0d accesses=%0d bad=%0d expected 1 0 %0d 0", done, error, log_q.size(), bad, 2 * WORDS);
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    bit found = 1'b0;
    int bad = 0;
    log_q.delete();
    pulse_start(1'b0);
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk);
      if (request && write_enable && address == 16'd3) found = 1'b1;
    end
    pattern_sel = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (!found || address !== 16'd3 || request !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_start_hold: got found=%0d addr=%0d req=%0d expected 1 3 1", found, address, request);
    end
    wait_end(to);
    foreach (log_q[i]) if (log_q[i].addr != i / 2 || log_q[i].data !== pat(1'b0, i / 2)) bad++;
    n_tests++;
    if (to !== 1'b0 || done !== 1'b1 || log_q.size() != int'(2 * WORDS) || bad != 0) begin
      n_fail++;
      $display("FAIL ignore_start_pass: got done=%0d accesses=%0d bad=%0d expected 1 %0d 0", done, log_q.size(), bad, 2 * WORDS);
    end
  endtask

  task automatic test_init_low();
    bit to;
    int hi = 0;
    log_q.delete();
    initialized = 1'b0;
    pulse_start(1'b0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (request !== 1'b0 || address !== 16'd0) hi++;
    end
    n_tests++;
    if (hi != 0 || log_q.size() != 0) begin
      n_fail++;
      $display("FAIL init_low_hold: got %0d bad cycles %0d accesses expected 0 0", hi, log_q.size());
    end
    initialized = 1'b1;
    wait_end(to);
    n_tests++;
    if (to !== 1'b0 || done !== 1'b1 || error !== 1'b0 || log_q.size() != int'(2 * WORDS)) begin
      n_fail++;
      $display("FAIL init_low_pass: got done=%0d error=%0d accesses=%0d expected 1 0 %0d", done, error, log_q.size(), 2 * WORDS);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit found = 1'b0;
    log_q.delete();
    pulse_start(1'b0);
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk);
      if (request && !write_enable && address == 16'd3) found = 1'b1;
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (!found || out_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_mid_async: got found=%0d vec=%h expected 1 and %h", found, out_vec(), RESET_VEC);
    end
    @(negedge clk);
    n_tests++;
    if (out_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_mid_held: got %h expected %h", out_vec(), RESET_VEC);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    log_q.delete();
    pulse_start(1'b0);
    wait_end(to);
    n_tests++;
    if (to !== 1'b0 || done !== 1'b1 || log_q.size() != int'(2 * WORDS) || log_q[0].addr != 0) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: got done=%0d accesses=%0d expected 1 %0d from address 0", done, log_q.size(), 2 * WORDS);
    end
  endtask

  initial begin
    test_reset();
    test_fill(1'b0);
    test_fill(1'b1);
    test_back_to_back();
    test_corrupt();
    test_start_in_fail();
    test_start_ignored();
    test_init_low();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
